if_fetch: RTL and testbench

//   Instruction-fetch front end and consumer of the PC register. Takes the current
//   PC, fetches one instruction byte-serially over the memory controller's req/ack

---
 rtl/if_fetch_pkg.sv | 17 +
 rtl/if_fetch_inst_assembler.sv | 39 +++
 rtl/if_fetch.sv | 122 ++++++++++++
 tb/tb_if_fetch.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared fetch state encoding and sizing helper
package if_fetch_pkg;

   // Fetch front-end states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_VALID = 2'd2,
      ST_DROP  = 2'd3
   } fetch_state_t;

   // Byte-counter width for an instruction of n memory beats (at least one bit)
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/if_fetch_inst_assembler.sv
// rtl/if_fetch_inst_assembler.sv - byte counter and little-endian lane buffer
module if_fetch_inst_assembler
   import if_fetch_pkg::*;
#(
   parameter int MEM_DW     = 8,
   parameter int INST_BYTES = 4,
   parameter int CNT_W      = cnt_width(INST_BYTES)
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         clr,
   input  logic                         we,
   input  logic [MEM_DW-1:0]            data_byte,
   output logic [INST_BYTES*MEM_DW-1:0] inst,
   output logic                         last,
   output logic [CNT_W-1:0]             cnt
);

   // Lane 0 sits in the least significant bits, so the buffer is little-endian
   logic [INST_BYTES-1:0][MEM_DW-1:0] lanes;

   assign last = (cnt == CNT_W'(INST_BYTES - 1));
   assign inst = lanes;

   // Write the returned byte into the lane selected by cnt, then advance;
   // clr restarts the count but leaves stale lanes (they are overwritten anyway)
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt   <= '0;
         lanes <= '0;
      end else if (clr) begin
         cnt   <= '0;
      end else if (we) begin
         lanes[cnt] <= data_byte;
         cnt        <= last ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - byte-serial instruction fetch with branch cancel
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int MEM_DW = 8,
   parameter int INST_W = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              br,
   input  logic              stall_i,
   output logic [ADDR_W-1:0] pc_next_o,
   output logic              stall_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_ack_i,
   input  logic [MEM_DW-1:0] mem_data_i,
   output logic              inst_valid_o,
   output logic [INST_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_pc_o
);

   localparam int INST_BYTES = INST_W / MEM_DW;
   localparam int CNT_W      = cnt_width(INST_BYTES);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] drop_addr_q, drop_addr_d;
   logic [ADDR_W-1:0] fetch_addr;
   logic [CNT_W-1:0]  cnt;
   logic              asm_clr, asm_we, asm_last;
   logic [INST_W-1:0] asm_inst;

   if_fetch_inst_assembler #(
      .MEM_DW     (MEM_DW),
      .INST_BYTES (INST_BYTES),
      .CNT_W      (CNT_W)
   ) u_asm (
      .clock     (clock),
      .reset_n   (reset_n),
      .clr       (asm_clr),
      .we        (asm_we),
      .data_byte (mem_data_i),
      .inst      (asm_inst),
      .last      (asm_last),
      .cnt       (cnt)
   );

   // The PC register holds while stall_o=1, so pc_i+cnt is stable for a request
   assign fetch_addr = pc_i + ADDR_W'(cnt);
   assign pc_next_o  = pc_i + ADDR_W'(INST_BYTES);
   assign inst_o     = asm_inst;
   assign inst_pc_o  = pc_i;

   // PC only advances on the handoff cycle; a branch overrides the handoff
   assign stall_o = !((state_q == ST_VALID) && !stall_i && !br);

   // State and in-flight drop address
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         drop_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         drop_addr_q <= drop_addr_d;
      end
   end

   // Next state, memory request and assembler controls; br takes priority
   always_comb begin
      state_d      = state_q;
      drop_addr_d  = drop_addr_q;
      mem_req_o    = 1'b0;
      mem_addr_o   = fetch_addr;
      inst_valid_o = 1'b0;
      asm_clr      = 1'b0;
      asm_we       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            mem_req_o = 1'b1;
            if (br) begin
               if (mem_ack_i) begin
                  // Request completes now, so nothing is left outstanding
                  asm_clr = 1'b1;
               end else begin
                  // The request may not be withdrawn: finish it at the old address
                  drop_addr_d = fetch_addr;
                  state_d     = ST_DROP;
               end
            end else if (mem_ack_i) begin
               asm_we = 1'b1;
               if (asm_last) begin
                  state_d = ST_VALID;
               end
            end
         end
         ST_VALID: begin
            inst_valid_o = 1'b1;
            if (br || !stall_i) begin
               asm_clr = 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_DROP: begin
            mem_req_o  = 1'b1;
            mem_addr_o = drop_addr_q;
            if (mem_ack_i) begin
               asm_clr = 1'b1;
               state_d = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - randomized self-checking bench for if_fetch
module tb_if_fetch;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] pc_i = 32'h0;
   logic        br = 1'b0;
   logic        stall_i = 1'b0;
   logic [31:0] pc_next_o;
   logic        stall_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ack_i = 1'b0;
   logic [7:0]  mem_data_i = 8'h0;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;

   if_fetch #(.ADDR_W(32), .MEM_DW(8), .INST_W(32)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .pc_i         (pc_i),
      .br           (br),
      .stall_i      (stall_i),
      .pc_next_o    (pc_next_o),
      .stall_o      (stall_o),
      .mem_req_o    (mem_req_o),
      .mem_addr_o   (mem_addr_o),
      .mem_ack_i    (mem_ack_i),
      .mem_data_i   (mem_data_i),
      .inst_valid_o (inst_valid_o),
      .inst_o       (inst_o),
      .inst_pc_o    (inst_pc_o)
   );

   always #5 clock = ~clock;

   int vectors = 0;
   int miscompares = 0;

   // Behavioural model: what the front end owes the PC register and IF/ID
   int          m_idle_left;
   int          m_got;
   bit          m_full;
   bit          m_drop;
   logic [31:0] m_drop_addr;
   logic [31:0] m_pc;

   // Last sampled DUT outputs, for the directed literal checks
   logic        s_req, s_valid, s_stall;
   logic [31:0] s_addr, s_inst, s_inst_pc, s_pc_next;
   int          stall_low_cnt;
   logic [31:0] addr_log[$];

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      case (a)
         32'h0000_0100: return 8'h13;
         32'h0000_0101: return 8'h05;
         32'h0000_0102: return 8'hA0;
         32'h0000_0103: return 8'h00;
         default:       return (a[7:0] * 8'h1D) ^ a[15:8] ^ a[31:24] ^ 8'h5A;
      endcase
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] pc);
      return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2),
              mem_byte(pc + 32'd1), mem_byte(pc)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle, entered and left at a falling edge
   task automatic cycle(input bit br_v, input logic [31:0] br_a, input bit st_v, input bit ack_v);
      logic        exp_req, exp_stall;
      logic [31:0] exp_addr;
      pc_i      = m_pc;
      br        = br_v;
      stall_i   = st_v;
      mem_ack_i = ack_v;
      #1;
      mem_data_i = !ack_v ? 8'h00 : (mem_req_o ? mem_byte(mem_addr_o) : 8'($urandom));
      #1;
      s_req = mem_req_o;  s_addr = mem_addr_o;  s_valid = inst_valid_o;
      s_inst = inst_o;    s_inst_pc = inst_pc_o; s_pc_next = pc_next_o;
      s_stall = stall_o;
      exp_req   = (m_idle_left == 0) && !m_full;
      exp_addr  = m_drop ? m_drop_addr : m_pc + 32'(m_got);
      exp_stall = !(m_full && !st_v && !br_v);
      check("mem_req_o", 32'(s_req), 32'(exp_req));
      if (exp_req) check("mem_addr_o", s_addr, exp_addr);
      check("inst_valid_o", 32'(s_valid), 32'(m_full));
      if (m_full) begin
         check("inst_o", s_inst, mem_word(m_pc));
         check("inst_pc_o", s_inst_pc, m_pc);
      end
      check("pc_next_o", s_pc_next, m_pc + 32'd4);
      check("stall_o", 32'(s_stall), 32'(exp_stall));
      if (!s_stall) stall_low_cnt++;
      if (s_req && ack_v) addr_log.push_back(s_addr);
      // advance the model by one clock
      if (m_idle_left > 0) begin
         m_idle_left--;
      end else if (m_drop) begin
         if (ack_v) begin m_drop = 1'b0; m_got = 0; end
      end else if (m_full) begin
         if (br_v || !st_v) begin m_full = 1'b0; m_got = 0; end
      end else if (br_v) begin
         if (!ack_v) begin m_drop = 1'b1; m_drop_addr = m_pc + 32'(m_got); end
         m_got = 0;
      end else if (ack_v) begin
         m_got++;
         if (m_got == 4) m_full = 1'b1;
      end
      if (br_v) m_pc = br_a;
      else if (!exp_stall) m_pc = m_pc + 32'd4;
      @(negedge clock);
   endtask

   // Asynchronous reset from a falling edge, released two edges later
   task automatic do_reset(input logic [31:0] pc);
      reset_n = 1'b0; br = 1'b0; stall_i = 1'b0; mem_ack_i = 1'b0;
      #1;
      check("reset mem_req_o", 32'(mem_req_o), 32'd0);
      check("reset inst_valid_o", 32'(inst_valid_o), 32'd0);
      check("reset stall_o", 32'(stall_o), 32'd1);
      check("reset inst_o", inst_o, 32'd0);
      @(negedge clock);
      @(negedge clock);
      m_idle_left = 1; m_got = 0; m_full = 1'b0; m_drop = 1'b0;
      m_drop_addr = 32'd0; m_pc = pc;
      reset_n = 1'b1;
   endtask

   initial begin
      @(negedge clock);

      // zero-wait fetch at 0x100, then three stalled cycles and a handoff
      do_reset(32'h100);
      addr_log.delete();
      cycle(0, 0, 0, 1);
      check("idle no req", 32'(s_req), 32'd0);
      repeat (4) cycle(0, 0, 0, 1);
      check("t1 acked beats", 32'(addr_log.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < addr_log.size()) check("t1 mem_addr", addr_log[i], 32'h100 + 32'(i));
      end
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 1, 1);
         check("t2 held valid", 32'(s_valid), 32'd1);
         check("t2 held inst", s_inst, 32'h00A0_0513);
         check("t2 held stall", 32'(s_stall), 32'd1);
         check("t2 no req", 32'(s_req), 32'd0);
      end
      stall_low_cnt = 0;
      cycle(0, 0, 0, 1);
      check("t1 handoff stall", 32'(s_stall), 32'd0);
      check("t1 inst", s_inst, 32'h00A0_0513);
      check("t1 inst_pc", s_inst_pc, 32'h100);
      check("t1 pc_next", s_pc_next, 32'h104);
      cycle(0, 0, 0, 1);
      check("t1 next addr", s_addr, 32'h104);
      check("t1 stall low cycles", 32'(stall_low_cnt), 32'd1);

      // delayed byte-1 ack with a branch in the second wait cycle
      do_reset(32'h100);
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 0);
      check("t3 wait addr", s_addr, 32'h101);
      cycle(1, 32'h200, 0, 0);
      cycle(0, 0, 0, 0);
      check("t3 drop req", 32'(s_req), 32'd1);
      check("t3 drop addr", s_addr, 32'h101);
      cycle(0, 0, 0, 1);
      check("t3 drop ack addr", s_addr, 32'h101);
      cycle(0, 0, 0, 1);
      check("t3 refetch addr", s_addr, 32'h200);
      repeat (3) cycle(0, 0, 0, 1);
      cycle(0, 0, 1, 0);
      check("t3 valid", 32'(s_valid), 32'd1);
      check("t3 inst_pc", s_inst_pc, 32'h200);

      // branch together with the byte-2 ack, then branch in VALID
      do_reset(32'h100);
      repeat (3) cycle(0, 0, 0, 1);
      cycle(1, 32'h300, 0, 1);
      cycle(0, 0, 0, 1);
      check("t4 restart addr", s_addr, 32'h300);
      cycle(0, 0, 0, 1);
      check("t4 no drop addr", s_addr, 32'h301);
      repeat (2) cycle(0, 0, 0, 1);
      cycle(1, 32'h400, 0, 1);
      check("t5 valid on br", 32'(s_valid), 32'd1);
      check("t5 stall on br", 32'(s_stall), 32'd1);
      cycle(0, 0, 0, 1);
      check("t5 valid after br", 32'(s_valid), 32'd0);
      check("t5 addr after br", s_addr, 32'h400);

      // reset mid-fetch with cnt=2 at the top of the address space
      do_reset(32'hFFFF_FFFC);
      repeat (3) cycle(0, 0, 0, 1);
      do_reset(32'hFFFF_FFFC);
      cycle(0, 0, 0, 1);
      check("t6 idle after reset", 32'(s_req), 32'd0);
      check("t6 pc_next wrap", s_pc_next, 32'h0000_0000);
      cycle(0, 0, 0, 1);
      check("t6 restart addr", s_addr, 32'hFFFF_FFFC);
      repeat (4) cycle(0, 0, 1, 1);

      // randomized traffic against the model
      do_reset($urandom);
      for (int n = 0; n < 4000; n++) begin
         logic [31:0] ba;
         ba = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
         if ($urandom_range(0, 599) == 0) begin
            do_reset(ba);
         end else begin
            cycle($urandom_range(0, 11) == 0, ba, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 1) == 1);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
